// File: rtl/mem_readback_streamer.sv
// Read-side initiator for a 1-cycle registered-read block RAM.
// Sweeps `count` words from `base_addr` (wrapping at DEPTH_MEM) and streams
// them out on a valid/ready interface with a last flag and running checksum.
module mem_readback_streamer #(
   parameter int WID_MEM    = 4,
   parameter int DEPTH_MEM  = 4096,
   parameter int FIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [31:0]        base_addr,
   input  logic [31:0]        count,
   output logic               busy,
   output logic               done,
   output logic [31:0]        mem_raddr,
   input  logic [WID_MEM-1:0] mem_dout,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [WID_MEM-1:0] m_data,
   output logic               m_last,
   output logic [31:0]        checksum
);

   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int UW = $clog2(FIFO_DEPTH + 1);
   localparam int OW = UW + 1;
   localparam logic [31:0]   DEPTH_W   = 32'(DEPTH_MEM);
   localparam logic [31:0]   LAST_ADDR = 32'(DEPTH_MEM - 1);
   localparam logic [PW-1:0] PTR_MAX   = PW'(FIFO_DEPTH - 1);
   localparam logic [OW-1:0] OCC_MAX   = OW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state_q, state_d;
   logic [31:0]        addr_q;
   logic [31:0]        remaining_q;
   // rd1: read issued last edge (memory sampling address now)
   // rd2: memory data valid on mem_dout now, captured at the next edge
   logic               rd1_q, rd2_q;
   logic               last1_q, last2_q;
   logic [WID_MEM-1:0] fifo_data [FIFO_DEPTH];
   logic               fifo_last [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [UW-1:0]      used;
   logic [OW-1:0]      occupancy;
   logic               accept, issue, push, pop;

   assign accept    = (state_q == IDLE) && start;
   assign push      = rd2_q;
   assign pop       = m_valid && m_ready;
   // In-flight reads count against FIFO space so every capture has a free slot.
   assign occupancy = OW'(used) + OW'(rd1_q) + OW'(rd2_q);
   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);

   // Stream outputs come straight from the FIFO head, forced low when empty.
   always_comb begin
      m_valid = 1'b0;
      m_data  = '0;
      m_last  = 1'b0;
      if (used != '0) begin
         m_valid = 1'b1;
         m_data  = fifo_data[rd_ptr];
         m_last  = fifo_last[rd_ptr];
      end
   end

   // Next-state and read-issue decision.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = (count == '0) ? DONE : RUN;
         end
         RUN: begin
            if (occupancy < OCC_MAX) begin
               issue = 1'b1;
               if (remaining_q == 32'd1) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && m_last) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Address generation, read pipeline tracking and checksum.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q      <= '0;
         remaining_q <= '0;
         mem_raddr   <= '0;
         rd1_q       <= 1'b0;
         rd2_q       <= 1'b0;
         last1_q     <= 1'b0;
         last2_q     <= 1'b0;
         checksum    <= '0;
      end else begin
         if (accept) begin
            checksum    <= '0;
            remaining_q <= count;
            addr_q      <= base_addr % DEPTH_W;
         end else if (pop) begin
            checksum <= checksum + 32'(m_data);
         end
         if (issue) begin
            mem_raddr   <= addr_q;
            addr_q      <= (addr_q == LAST_ADDR) ? '0 : addr_q + 32'd1;
            remaining_q <= remaining_q - 32'd1;
         end
         rd1_q   <= issue;
         last1_q <= issue && (remaining_q == 32'd1);
         rd2_q   <= rd1_q;
         last2_q <= last1_q;
      end
   end

   // FIFO pointers and occupancy; simultaneous push and pop leaves `used` unchanged.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         used   <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + PW'(1);
         if (pop)  rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   used <= used + UW'(1);
            2'b01:   used <= used - UW'(1);
            default: used <= used;
         endcase
      end
   end

   // FIFO storage; contents are only visible through the head while non-empty.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= mem_dout;
         fifo_last[wr_ptr] <= last2_q;
      end
   end

endmodule

// File: tb/tb_mem_readback_streamer.sv
// Self-checking bench for mem_readback_streamer: a registered-read memory
// model plus a word-level reference of what each sweep must deliver.
module tb_mem_readback_streamer;

   localparam int WID   = 4;
   localparam int DEPTH = 4096;
   localparam int FD    = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           start;
   logic [31:0]    base_addr;
   logic [31:0]    count;
   logic           busy;
   logic           done;
   logic [31:0]    mem_raddr;
   logic [WID-1:0] mem_dout;
   logic           m_valid;
   logic           m_ready;
   logic [WID-1:0] m_data;
   logic           m_last;
   logic [31:0]    checksum;

   logic [WID-1:0] ram [DEPTH];

   int n_cmp = 0;
   int n_err = 0;

   mem_readback_streamer #(
      .WID_MEM    (WID),
      .DEPTH_MEM  (DEPTH),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .base_addr (base_addr),
      .count     (count),
      .busy      (busy),
      .done      (done),
      .mem_raddr (mem_raddr),
      .mem_dout  (mem_dout),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .m_data    (m_data),
      .m_last    (m_last),
      .checksum  (checksum)
   );

   always #5 clk = ~clk;

   // Block RAM with a one-cycle registered read.
   always @(posedge clk) mem_dout <= ram[mem_raddr % DEPTH];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_valid"}, m_valid, 0);
      check({tag, "_last"}, m_last, 0);
      check({tag, "_raddr"}, mem_raddr, 0);
      check({tag, "_cksum"}, checksum, 0);
   endtask

   // mode 0: ready always high; 1: ready random 50% plus an ignored start;
   // 2: ready high except a 20-cycle stall. abort_at >= 0 pulls reset low
   // once that many words have been accepted.
   task automatic run_sweep(input logic [31:0] base, input int unsigned cnt, input int mode,
                            input int abort_at, input bit chk_lat);
      int unsigned b0;
      int unsigned idx = 0;
      int unsigned n_iss = 0;
      int          cyc;
      int          budget;
      int          first_v = -1;
      int          first_x = -1;
      int          last_x = -1;
      bit          fin = 0;
      logic [31:0] sum = '0;
      logic [31:0] prev_raddr;
      logic        pv = 1'b0;
      logic        pr = 1'b0;
      logic        plast = 1'b0;
      logic [WID-1:0] pdata = '0;
      logic [WID-1:0] exp_w;
      b0 = base % DEPTH;
      budget = int'(cnt) * 6 + 200;

      @(negedge clk);
      start = 1'b1;
      base_addr = base;
      count = cnt;
      m_ready = 1'b1;
      prev_raddr = mem_raddr;
      @(negedge clk);
      start = 1'b0;
      base_addr = $urandom;
      count = $urandom;
      cyc = 1;

      while (!fin && cyc < budget) begin
         case (mode)
            1:       m_ready = 1'($urandom_range(0, 1));
            2:       m_ready = !(cyc >= 15 && cyc < 35);
            default: m_ready = 1'b1;
         endcase

         if (abort_at >= 0 && idx == abort_at) begin
            reset = 1'b0;
            #1;
            check_idle_outputs("abort");
            repeat (3) @(negedge clk);
            check_idle_outputs("abort_hold");
            reset = 1'b1;
            repeat (6) begin
               @(negedge clk);
               check("stale_valid", m_valid, 0);
               check("stale_done", done, 0);
            end
            return;
         end

         if (mode == 1 && cyc == 10) start = 1'b1;
         else start = 1'b0;

         check("busy", busy, 1);

         if (pv && !pr) begin
            check("hold_valid", m_valid, 1);
            check("hold_data", m_data, pdata);
            check("hold_last", m_last, plast);
         end

         if ((cyc == 2 && cnt > 0) || (cyc > 2 && mem_raddr != prev_raddr)) begin
            check("raddr", mem_raddr, (b0 + n_iss) % DEPTH);
            n_iss++;
            check("ahead", (n_iss <= idx + FD), 1);
         end

         if (mode == 2 && cyc == 34) check("stall_full", n_iss - idx, FD);
         if (cnt == 0) check("zero_valid", m_valid, 0);
         if (m_valid && first_v < 0) first_v = cyc;

         if (m_valid && m_ready) begin
            if (idx >= cnt) begin
               check("extra_word", idx, cnt - 1);
            end else begin
               exp_w = ram[(b0 + idx) % DEPTH];
               check("data", m_data, exp_w);
               check("last", m_last, (idx == cnt - 1));
               sum = sum + 32'(exp_w);
            end
            if (first_x < 0) first_x = cyc;
            last_x = cyc;
            idx++;
         end

         if (done) begin
            fin = 1;
            check("words", idx, cnt);
            check("issued", n_iss, cnt);
            check("cksum", checksum, sum);
            check("done_time", cyc, (cnt == 0) ? 1 : last_x + 1);
            if (chk_lat && cnt > 0) check("latency", first_v, 4);
            if (mode == 0 && cnt > 0) check("no_bubble", last_x - first_x, cnt - 1);
         end

         pv = m_valid;
         pr = m_ready;
         pdata = m_data;
         plast = m_last;
         prev_raddr = mem_raddr;
         if (!fin) begin
            @(negedge clk);
            cyc++;
         end
      end

      if (!fin) begin
         check("timeout", 0, 1);
      end else begin
         @(negedge clk);
         start = 1'b0;
         check("done_pulse", done, 0);
         check("busy_end", busy, 0);
         check("cksum_hold", checksum, sum);
      end
   endtask

   initial begin
      for (int k = 0; k < DEPTH; k++) ram[k] = WID'(k % 16);
      reset = 1'b0;
      start = 1'b0;
      base_addr = '0;
      count = '0;
      m_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_outputs("reset");
      reset = 1'b1;
      @(negedge clk);
      check_idle_outputs("post_reset");

      run_sweep(32'd0, 8, 0, -1, 1);
      check("t1_cksum", checksum, 28);
      run_sweep(32'd4094, 4, 0, -1, 1);
      run_sweep(32'd123, 0, 0, -1, 0);

      for (int k = 0; k < DEPTH; k++) ram[k] = WID'($urandom);
      run_sweep($urandom, 64, 1, -1, 0);
      run_sweep(32'($urandom_range(4000, 4095)), 48, 2, -1, 0);
      run_sweep($urandom, 32, 0, 10, 0);
      run_sweep($urandom, 3, 0, -1, 1);
      for (int r = 0; r < 6; r++)
         run_sweep(32'($urandom_range(4080, 4095)), $urandom_range(1, 24), 1, -1, 0);
      run_sweep(32'd4090, DEPTH + 10, 0, -1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
